// File: rtl/alarm_pkg.sv
// Shared types and BCD limits for the alarm controller.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } alarm_state_e;

    localparam logic [3:0] HOURDEC_MAX      = 4'd2;
    localparam logic [3:0] HOURONE_MAX_AT_2 = 4'd3;
    localparam logic [3:0] MINDEC_MAX       = 4'd5;
    localparam logic [3:0] DIGIT_MAX        = 4'd9;

    typedef struct packed {
        logic [3:0] hourdec;
        logic [3:0] hourone;
        logic [3:0] mindec;
        logic [3:0] minone;
    } bcd_hm_t;

    // True when the hh:mm value is a valid 24-hour BCD time.
    function automatic logic bcd_hm_legal(input bcd_hm_t t);
        logic hour_ok;
        hour_ok = ((t.hourdec < HOURDEC_MAX) && (t.hourone <= DIGIT_MAX)) ||
                  ((t.hourdec == HOURDEC_MAX) && (t.hourone <= HOURONE_MAX_AT_2));
        return hour_ok && (t.mindec <= MINDEC_MAX) && (t.minone <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave phase generator for the buzzer; restart forces a fresh high half-period.
module tone_gen #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TONE_HZ = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic phase
);

    localparam int unsigned HALF_RAW = CLK_HZ / (2 * TONE_HZ);
    localparam int unsigned HALF     = (HALF_RAW > 0) ? HALF_RAW : 1;
    localparam int unsigned CW       = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (enable) begin
            if (cnt_q == CW'(HALF - 1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: stores the alarm time, detects the alarm minute and runs
// the ring / snooze / stop sequence with a gated buzzer tone.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned TONE_HZ    = 1000,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hourdec_now,
    input  logic [3:0] hourone_now,
    input  logic [3:0] mindec_now,
    input  logic [3:0] minone_now,
    input  logic [2:0] decsec_now,
    input  logic [3:0] sec_now,
    input  logic       alarm_en,
    input  logic       set_valid,
    input  logic [3:0] set_hourdec,
    input  logic [3:0] set_hourone,
    input  logic [3:0] set_mindec,
    input  logic [3:0] set_minone,
    input  logic       stop,
    input  logic       snooze,
    output logic [3:0] alarm_hourdec,
    output logic [3:0] alarm_hourone,
    output logic [3:0] alarm_mindec,
    output logic [3:0] alarm_minone,
    output logic       set_err,
    output logic       ringing,
    output logic       snoozing,
    output logic       sound
);

    localparam int unsigned SNOOZE_SEC = SNOOZE_MIN * 60;
    localparam int unsigned SEC_MAX    = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int unsigned PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned SW         = $clog2(SEC_MAX + 1);

    alarm_state_e  state_q, state_d;
    bcd_hm_t       alarm_q, alarm_d;
    bcd_hm_t       now_hm, set_hm;
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] sec_q, sec_d;
    logic          match_c, match_q;
    logic          trigger_c, wrap_c, tone_restart_c, phase;
    logic          set_err_q, set_err_d;
    logic          ringing_q, ringing_d;
    logic          snoozing_q, snoozing_d;

    assign now_hm = {hourdec_now, hourone_now, mindec_now, minone_now};
    assign set_hm = {set_hourdec, set_hourone, set_mindec, set_minone};

    // match_q starts high so a release from reset at 00:00:00 is not an edge.
    assign match_c   = (now_hm == alarm_q) && (decsec_now == 3'd0) && (sec_now == 4'd0);
    assign trigger_c = match_c && !match_q && alarm_en && (state_q == ST_IDLE);
    assign wrap_c    = (presc_q == PW'(CLK_HZ - 1));

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        sec_d      = sec_q;
        alarm_d    = alarm_q;
        set_err_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (trigger_c) state_d = ST_RING;
            end
            ST_RING: begin
                if (stop)                                        state_d = ST_IDLE;
                else if (snooze)                                 state_d = ST_SNOOZE;
                else if (wrap_c && (sec_q == SW'(RING_SEC - 1))) state_d = ST_IDLE;
            end
            ST_SNOOZE: begin
                if (stop)                                          state_d = ST_IDLE;
                else if (wrap_c && (sec_q == SW'(SNOOZE_SEC - 1))) state_d = ST_RING;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!alarm_en) state_d = ST_IDLE;

        // Second counters restart on every state change so each phase is timed from entry.
        if (state_d != state_q) begin
            presc_d = '0;
            sec_d   = '0;
        end else if (wrap_c) begin
            presc_d = '0;
            sec_d   = (state_q == ST_IDLE) ? '0 : sec_q + SW'(1);
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (set_valid) begin
            if (bcd_hm_legal(set_hm)) alarm_d   = set_hm;
            else                      set_err_d = 1'b1;
        end

        ringing_d      = (state_d == ST_RING);
        snoozing_d     = (state_d == ST_SNOOZE);
        tone_restart_c = (state_d == ST_RING) && (state_q != ST_RING);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            alarm_q    <= '0;
            presc_q    <= '0;
            sec_q      <= '0;
            match_q    <= 1'b1;
            set_err_q  <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            alarm_q    <= alarm_d;
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            match_q    <= match_c;
            set_err_q  <= set_err_d;
            ringing_q  <= ringing_d;
            snoozing_q <= snoozing_d;
        end
    end

    tone_gen #(
        .CLK_HZ  (CLK_HZ),
        .TONE_HZ (TONE_HZ)
    ) u_tone_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (tone_restart_c),
        .enable  (ringing_q),
        .phase   (phase)
    );

    // Beep during the first half of each ring second, gated by the tone phase.
    assign sound = ringing_q & phase & (presc_q < PW'(CLK_HZ / 2));

    assign alarm_hourdec = alarm_q.hourdec;
    assign alarm_hourone = alarm_q.hourone;
    assign alarm_mindec  = alarm_q.mindec;
    assign alarm_minone  = alarm_q.minone;
    assign set_err       = set_err_q;
    assign ringing       = ringing_q;
    assign snoozing      = snoozing_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed scenarios plus random traffic
// compared against a cycle-count model of the alarm behaviour.
module tb_alarm_ctrl;

    localparam int unsigned CLK_HZ     = 100;
    localparam int unsigned TONE_HZ    = 10;
    localparam int unsigned RING_SEC   = 3;
    localparam int unsigned SNOOZE_MIN = 1;
    localparam int RING_CYC   = RING_SEC * CLK_HZ;
    localparam int SNOOZE_CYC = SNOOZE_MIN * 60 * CLK_HZ;
    localparam int HALF       = CLK_HZ / (2 * TONE_HZ);
    localparam int M_IDLE = 0, M_RING = 1, M_SNOOZE = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] hourdec_now, hourone_now, mindec_now, minone_now, sec_now;
    logic [2:0] decsec_now;
    logic       alarm_en, set_valid, stop, snooze;
    logic [3:0] set_hourdec, set_hourone, set_mindec, set_minone;
    logic [3:0] alarm_hourdec, alarm_hourone, alarm_mindec, alarm_minone;
    logic       set_err, ringing, snoozing, sound;

    always #5 clk = ~clk;

    alarm_ctrl #(
        .CLK_HZ(CLK_HZ), .TONE_HZ(TONE_HZ), .RING_SEC(RING_SEC), .SNOOZE_MIN(SNOOZE_MIN)
    ) dut (
        .clk(clk), .rst(rst),
        .hourdec_now(hourdec_now), .hourone_now(hourone_now),
        .mindec_now(mindec_now), .minone_now(minone_now),
        .decsec_now(decsec_now), .sec_now(sec_now),
        .alarm_en(alarm_en), .set_valid(set_valid),
        .set_hourdec(set_hourdec), .set_hourone(set_hourone),
        .set_mindec(set_mindec), .set_minone(set_minone),
        .stop(stop), .snooze(snooze),
        .alarm_hourdec(alarm_hourdec), .alarm_hourone(alarm_hourone),
        .alarm_mindec(alarm_mindec), .alarm_minone(alarm_minone),
        .set_err(set_err), .ringing(ringing), .snoozing(snoozing), .sound(sound)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode plus number of cycles already spent in that mode.
    int          m_mode, m_t;
    logic [15:0] m_alarm;
    logic        m_match_q, m_err;

    function automatic bit legal_hm(input logic [15:0] v);
        int hd, ho, md, mo;
        hd = int'(v[15:12]); ho = int'(v[11:8]); md = int'(v[7:4]); mo = int'(v[3:0]);
        return (hd <= 2) && (ho <= 9) && (hd * 10 + ho <= 23) && (md <= 5) && (mo <= 9);
    endfunction

    function automatic bit exp_sound();
        return (m_mode == M_RING) && ((m_t % CLK_HZ) < CLK_HZ / 2) && (((m_t / HALF) % 2) == 0);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_t = 0; m_alarm = '0; m_match_q = 1'b1; m_err = 1'b0;
    endtask

    task automatic model_step();
        bit match, trig;
        int nmode;
        if (rst) begin
            model_reset();
            return;
        end
        match = ({hourdec_now, hourone_now, mindec_now, minone_now} == m_alarm) &&
                (decsec_now == 3'd0) && (sec_now == 4'd0);
        trig  = match && !m_match_q && alarm_en && (m_mode == M_IDLE);
        nmode = m_mode;
        if (!alarm_en) nmode = M_IDLE;
        else if (m_mode == M_IDLE) begin
            if (trig) nmode = M_RING;
        end else if (m_mode == M_RING) begin
            if (stop) nmode = M_IDLE;
            else if (snooze) nmode = M_SNOOZE;
            else if (m_t + 1 == RING_CYC) nmode = M_IDLE;
        end else begin
            if (stop) nmode = M_IDLE;
            else if (m_t + 1 == SNOOZE_CYC) nmode = M_RING;
        end
        m_t    = (nmode != m_mode) ? 0 : m_t + 1;
        m_mode = nmode;
        m_err  = 1'b0;
        if (set_valid) begin
            if (legal_hm({set_hourdec, set_hourone, set_mindec, set_minone}))
                m_alarm = {set_hourdec, set_hourone, set_mindec, set_minone};
            else
                m_err = 1'b1;
        end
        m_match_q = match;
    endtask

    task automatic compare_all();
        check("ringing",  32'(ringing),  32'(m_mode == M_RING));
        check("snoozing", 32'(snoozing), 32'(m_mode == M_SNOOZE));
        check("sound",    32'(sound),    32'(exp_sound()));
        check("set_err",  32'(set_err),  32'(m_err));
        check("alarm",    32'({alarm_hourdec, alarm_hourone, alarm_mindec, alarm_minone}), 32'(m_alarm));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        set_valid = 1'b0;
        stop      = 1'b0;
        snooze    = 1'b0;
    endtask

    task automatic set_time(input logic [15:0] hm, input int ds, input int s);
        {hourdec_now, hourone_now, mindec_now, minone_now} = hm;
        decsec_now = 3'(ds);
        sec_now    = 4'(s);
    endtask

    task automatic do_set(input logic [15:0] hm);
        {set_hourdec, set_hourone, set_mindec, set_minone} = hm;
        set_valid = 1'b1;
        tick();
    endtask

    // Step off the alarm minute then onto it, producing a fresh match edge.
    task automatic ring_up();
        set_time(m_alarm, 0, 1);
        tick();
        set_time(m_alarm, 0, 0);
        tick();
        check("ring_up", 32'(ringing), 32'd1);
    endtask

    int n_ring, n_sound, r;

    initial begin
        rst = 1'b1; alarm_en = 1'b1; set_valid = 1'b0; stop = 1'b0; snooze = 1'b0;
        set_hourdec = '0; set_hourone = '0; set_mindec = '0; set_minone = '0;
        set_time(16'h0000, 0, 0);
        model_reset();
        repeat (3) tick();
        rst = 1'b0;

        // Release at 00:00:00 with alarm 00:00 must stay silent.
        n_ring = 0;
        repeat (200) begin tick(); n_ring += int'(ringing); end
        check("no_ring_after_reset", 32'(n_ring), 32'd0);

        // Ring at 07:30, count ring and beep cycles, no re-trigger while held.
        do_set(16'h0730);
        set_time(16'h0729, 5, 9);
        tick();
        set_time(16'h0730, 0, 0);
        tick();
        check("ring_start", 32'(ringing), 32'd1);
        check("first_beep", 32'(sound), 32'd1);
        n_ring = int'(ringing); n_sound = int'(sound);
        repeat (RING_CYC + 20) begin tick(); n_ring += int'(ringing); n_sound += int'(sound); end
        check("ring_len", 32'(n_ring), 32'(RING_CYC));
        check("beep_len", 32'(n_sound), 32'(RING_SEC * (CLK_HZ / 2) / 2));

        // Illegal then legal set.
        do_set(16'h2400);
        check("set_err_illegal", 32'(set_err), 32'd1);
        check("alarm_kept", 32'({alarm_hourdec, alarm_hourone, alarm_mindec, alarm_minone}), 32'h0730);
        tick();
        check("set_err_oneshot", 32'(set_err), 32'd0);
        do_set(16'h2359);
        check("set_err_legal", 32'(set_err), 32'd0);
        check("alarm_2359", 32'({alarm_hourdec, alarm_hourone, alarm_mindec, alarm_minone}), 32'h2359);

        // Snooze, then re-ring with a fresh window.
        ring_up();
        repeat (10) tick();
        snooze = 1'b1;
        tick();
        check("snooze_entry", 32'(snoozing), 32'd1);
        check("snooze_quiet", 32'(sound), 32'd0);
        repeat (SNOOZE_CYC - 1) tick();
        check("snooze_end_minus1", 32'(snoozing), 32'd1);
        tick();
        check("re_ring", 32'(ringing), 32'd1);
        n_ring = 1;
        repeat (RING_CYC + 10) begin tick(); n_ring += int'(ringing); end
        check("re_ring_len", 32'(n_ring), 32'(RING_CYC));

        // stop wins over snooze.
        ring_up();
        repeat (3) tick();
        stop = 1'b1; snooze = 1'b1;
        tick();
        check("stop_wins_ring", 32'(ringing), 32'd0);
        check("stop_wins_snz", 32'(snoozing), 32'd0);

        // Dropping alarm_en silences next cycle.
        ring_up();
        tick();
        alarm_en = 1'b0;
        tick();
        check("en_drop", 32'(ringing), 32'd0);
        alarm_en = 1'b1;
        tick();

        // Async reset mid-beep.
        ring_up();
        tick();
        check("mid_beep", 32'(sound), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_sound", 32'(sound), 32'd0);
        check("rst_ringing", 32'(ringing), 32'd0);
        check("rst_alarm", 32'({alarm_hourdec, alarm_hourone, alarm_mindec, alarm_minone}), 32'h0000);
        tick();
        rst = 1'b0;
        repeat (5) tick();

        // Random traffic against the model.
        do_set(16'h1245);
        for (int i = 0; i < 5000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) set_time(m_alarm, 0, 0);
            else if (r < 8)
                set_time({4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                          4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))},
                         int'($urandom_range(0, 5)), int'($urandom_range(0, 9)));
            if ($urandom_range(0, 99) < 2) begin
                {set_hourdec, set_hourone, set_mindec, set_minone} =
                    {4'($urandom_range(0, 3)), 4'($urandom_range(0, 11)),
                     4'($urandom_range(0, 7)), 4'($urandom_range(0, 10))};
                set_valid = 1'b1;
            end
            if ($urandom_range(0, 199) < 1) stop = 1'b1;
            if ($urandom_range(0, 99) < 2) snooze = 1'b1;
            if ($urandom_range(0, 299) < 1) alarm_en = ~alarm_en;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
